// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response plus the core-side handshake.
// The fetch unit is the master (it issues requests); memory and core form the slave side.
interface fetch_unit_if;
    logic        o_req;
    logic [31:0] o_req_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;

    modport master (
        output o_req, o_req_addr, o_valid, o_inst, o_pc,
        input  i_gnt, i_rvalid, i_rdata, i_ready, i_redirect, i_redirect_pc
    );
    modport slave (
        input  o_req, o_req_addr, o_valid, o_inst, o_pc,
        output i_gnt, i_rvalid, i_rdata, i_ready, i_redirect, i_redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: word-aligned requests to memory, in-order responses buffered
// with their PCs in a DEPTH-entry FIFO; a redirect flushes the FIFO and drops in-flight data.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input logic          i_clk,
    input logic          i_rst_n,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   f_pc_q, f_pc_d, r_pc_q, r_pc_d;
    logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, count_q, count_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic          up_q;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic          rsp, gnt, push, pop;
    logic [CW:0]   occ;
    logic [31:0]   redir_pc;

    // Room check uses registered occupancy only, so a same-cycle pop never frees a slot early.
    assign occ      = {1'b0, outst_q} + {1'b0, count_q};
    assign redir_pc = {bus.i_redirect_pc[31:2], 2'b00};
    assign rsp      = bus.i_rvalid && (outst_q != '0);
    assign bus.o_req = i_rst_n && up_q && !bus.i_redirect && (occ < (CW+1)'(DEPTH));
    assign gnt      = bus.o_req && bus.i_gnt;
    assign push     = rsp && (drop_q == '0) && !bus.i_redirect;
    assign bus.o_valid = i_rst_n && (count_q != '0) && !bus.i_redirect;
    assign pop      = bus.o_valid && bus.i_ready;

    assign bus.o_req_addr = f_pc_q;
    assign bus.o_inst     = inst_mem[rd_q];
    assign bus.o_pc       = pc_mem[rd_q];

    always_comb begin
        f_pc_d  = f_pc_q;
        r_pc_d  = r_pc_q;
        outst_d = outst_q + CW'(gnt) - CW'(rsp);
        drop_d  = drop_q;
        count_d = count_q + CW'(push) - CW'(pop);
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (gnt)                     f_pc_d = f_pc_q + 32'd4;
        if (rsp && (drop_q != '0))   drop_d = drop_q - CW'(1);
        if (push) begin
            r_pc_d = r_pc_q + 32'd4;
            wr_d   = wr_q + AW'(1);
        end
        if (pop)                     rd_d = rd_q + AW'(1);
        // Everything still in flight after this cycle belongs to the abandoned stream.
        if (bus.i_redirect) begin
            f_pc_d  = redir_pc;
            r_pc_d  = redir_pc;
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
            drop_d  = outst_q - CW'(rsp);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            f_pc_q  <= RESET_PC;
            r_pc_q  <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            up_q    <= 1'b0;
        end else begin
            f_pc_q  <= f_pc_d;
            r_pc_q  <= r_pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            up_q    <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            pc_mem[wr_q]   <= r_pc_q;
            inst_mem[wr_q] <= bus.i_rdata;
        end
    end

    a_no_orphan_rsp: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(bus.i_rvalid && (outst_q == '0)));
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model (expected PC stream, pending-response queue)
// checked every cycle, plus a redirect vector table and hand sequences for corner cases.
module tb_fetch_unit;
    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    typedef struct { logic [31:0] addr; int due; int epoch; } pend_t;
    typedef struct { logic [31:0] rpc; int lat; logic [31:0] pc0, pc1, pc2; } vec_t;

    pend_t       pend[$];
    logic [31:0] mfifo[$];
    logic [31:0] popped[$];
    logic [31:0] model_fpc;
    bit          up, fpc_known, lat_rand;
    int          cyc, epoch, lastdue, lat_fix, g_cnt;
    int          n_chk, n_fail;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_5A17;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait budget expired @cyc %0d", nm, cyc);
    endtask

    // One clock: memory drives its response, outputs checked at negedge, model advanced at posedge.
    task automatic cycle();
        bit    rv, e_req, e_val;
        int    due;
        pend_t p;
        rv = (pend.size() > 0) && (pend[0].due <= cyc);
        bus.i_rvalid = rv;
        bus.i_rdata  = rv ? memw(pend[0].addr) : $urandom;
        @(negedge clk);
        s_req = bus.o_req; s_addr = bus.o_req_addr; s_valid = bus.o_valid;
        s_pc = bus.o_pc;   s_inst = bus.o_inst;
        e_req = rst_n && up && !bus.i_redirect && (pend.size() + mfifo.size() < DEPTH);
        e_val = rst_n && (mfifo.size() != 0) && !bus.i_redirect;
        chk("o_req", s_req, e_req);
        chk("o_valid", s_valid, e_val);
        if (rst_n && fpc_known) chk("o_req_addr", s_addr, model_fpc);
        if (e_val && s_valid) begin
            chk("o_pc", s_pc, mfifo[0]);
            chk("o_inst", s_inst, memw(mfifo[0]));
        end
        if (rst_n && s_valid && bus.i_ready) popped.push_back(s_pc);
        @(posedge clk);
        if (!rst_n) begin
            pend.delete(); mfifo.delete();
            model_fpc = RPC; up = 0; fpc_known = 1; lastdue = cyc; epoch++;
        end else begin
            if (e_val && bus.i_ready) void'(mfifo.pop_front());
            if (rv) begin
                p = pend.pop_front();
                if (!bus.i_redirect && p.epoch == epoch) mfifo.push_back(p.addr);
            end
            if (e_req && bus.i_gnt) begin
                due = cyc + (lat_rand ? $urandom_range(1, 4) : lat_fix);
                if (due <= lastdue) due = lastdue + 1;
                lastdue = due;
                pend.push_back('{model_fpc, due, epoch});
                model_fpc += 32'd4;
                g_cnt++;
            end
            if (bus.i_redirect) begin
                epoch++;
                mfifo.delete();
                model_fpc = {bus.i_redirect_pc[31:2], 2'b00};
            end
            up = 1;
        end
        cyc++;
        #1;
    endtask

    task automatic wait_pops(input int n, input string nm);
        int k;
        k = 0;
        while (popped.size() < n && k < 40) begin cycle(); k++; end
        if (popped.size() < n) timeout(nm);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        bus.i_redirect = 1; bus.i_redirect_pc = pc;
        cycle();
        bus.i_redirect = 0; bus.i_redirect_pc = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[5];
        logic [31:0] lp;
        int          k;
        tbl[0] = '{32'h0000_2002, 1, 32'h0000_2000, 32'h0000_2004, 32'h0000_2008};
        tbl[1] = '{32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[2] = '{32'h0000_1003, 2, 32'h0000_1000, 32'h0000_1004, 32'h0000_1008};
        tbl[3] = '{32'h0000_0007, 3, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
        tbl[4] = '{32'hFFFF_FFFE, 4, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        n_chk = 0; n_fail = 0; cyc = 0; epoch = 0; lastdue = 0; g_cnt = 0;
        up = 0; fpc_known = 0; lat_rand = 0; lat_fix = 1; model_fpc = RPC;
        rst_n = 0;
        bus.i_gnt = 0; bus.i_rvalid = 0; bus.i_rdata = 0; bus.i_ready = 0;
        bus.i_redirect = 0; bus.i_redirect_pc = 0;
        @(posedge clk); #1;
        cycle(); cycle();
        chk("rst_addr", s_addr, RPC);

        // Free run from reset: 1-cycle memory, core always ready.
        rst_n = 1; bus.i_gnt = 1; bus.i_ready = 1;
        for (int i = 0; i < 23; i++) begin
            cycle();
            if (i == 0) chk("first_cycle_req", s_req, 1'b0);
            if (i == 1) begin chk("first_req", s_req, 1'b1); chk("first_addr", s_addr, RPC); end
            if (i == 2) chk("no_valid_yet", s_valid, 1'b0);
            if (i >= 3) begin
                chk("run_valid", s_valid, 1'b1);
                chk("run_pc", s_pc, RPC + 32'(4 * (i - 3)));
            end
        end

        // Backpressure: occupancy caps at DEPTH, then the stream resumes seamlessly.
        lp = popped[popped.size()-1];
        bus.i_ready = 0; g_cnt = 0;
        for (int i = 0; i < 10; i++) cycle();
        chk("bp_grants_le_depth", (g_cnt <= DEPTH), 1'b1);
        chk("bp_req_low", s_req, 1'b0);
        popped.delete();
        bus.i_ready = 1;
        wait_pops(1, "bp_resume");
        if (popped.size() > 0) chk("bp_resume_pc", popped[0], lp + 32'd4);
        for (int i = 0; i < 10; i++) cycle();

        // Redirect with three responses in flight on a 3-cycle memory.
        lat_fix = 3;
        k = 0;
        while (pend.size() < 3 && k < 20) begin cycle(); k++; end
        if (pend.size() < 3) timeout("inflight3");
        popped.delete();
        redirect_to(32'h0000_2002);
        cycle();
        chk("redir_req", s_req, 1'b1);
        chk("redir_addr", s_addr, 32'h0000_2000);
        wait_pops(1, "redir_first");
        if (popped.size() > 0) chk("redir_first_pc", popped[0], 32'h0000_2000);

        // Redirect coincident with a response, then back-to-back redirects.
        lat_fix = 2;
        k = 0;
        while (!(pend.size() > 0 && pend[0].due <= cyc) && k < 20) begin cycle(); k++; end
        if (k >= 20) timeout("coincident");
        popped.delete();
        redirect_to(32'h0000_0300);
        redirect_to(32'h0000_0040);
        redirect_to(32'h0000_0080);
        wait_pops(3, "b2b_stream");
        if (popped.size() >= 3) begin
            chk("b2b_pc0", popped[0], 32'h0000_0080);
            chk("b2b_pc1", popped[1], 32'h0000_0084);
            chk("b2b_pc2", popped[2], 32'h0000_0088);
        end

        // Redirect vector table, including address wrap.
        for (int i = 0; i < 5; i++) begin
            lat_fix = tbl[i].lat;
            for (int j = 0; j < 3; j++) cycle();
            popped.delete();
            redirect_to(tbl[i].rpc);
            wait_pops(3, "tbl_stream");
            if (popped.size() >= 3) begin
                chk("tbl_pc0", popped[0], tbl[i].pc0);
                chk("tbl_pc1", popped[1], tbl[i].pc1);
                chk("tbl_pc2", popped[2], tbl[i].pc2);
            end
        end

        // Reset with exactly two requests outstanding.
        lat_fix = 3;
        bus.i_gnt = 0;
        for (int i = 0; i < 8; i++) cycle();
        bus.i_gnt = 1;
        k = 0;
        while (pend.size() != 2 && k < 20) begin cycle(); k++; end
        if (pend.size() != 2) timeout("outst2");
        rst_n = 0; cycle(); rst_n = 1;
        cycle();
        chk("mid_rst_valid", s_valid, 1'b0);
        chk("mid_rst_req", s_req, 1'b0);
        popped.delete();
        cycle();
        chk("mid_rst_restart", s_req, 1'b1);
        chk("mid_rst_addr", s_addr, RPC);
        wait_pops(1, "mid_rst_stream");
        if (popped.size() > 0) chk("mid_rst_pc", popped[0], RPC);

        // Randomized traffic against the model.
        lat_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            bus.i_gnt      = ($urandom_range(0, 3) != 0);
            bus.i_ready    = ($urandom_range(0, 2) != 0);
            bus.i_redirect = ($urandom_range(0, 31) == 0);
            bus.i_redirect_pc = $urandom;
            rst_n = ($urandom_range(0, 399) != 0);
            cycle();
        end
        rst_n = 1; bus.i_redirect = 0;
        for (int i = 0; i < 10; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
